mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It is started by the control unit on MULT/DIV (funct 011000/011010) and holds the 64-bit result in HI/LO for the MFHI/MFLO write-back path. The unit exposes a start/busy/done handshake so the control FSM can hold in a wait state until the result is valid. HI/LO are architectural registers owned by this block.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Start/busy/done bus between the multicycle control FSM and the multiply/divide unit.
// The control unit drives the operation request; the unit returns status and HI/LO.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit owning HI/LO.
// One result bit per cycle; result committed to HI/LO on the FIX->DONE edge.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start raises busy on
// the same edge. When the result is committed, busy drops and done pulses for exactly
// one cycle; busy and done are never high together. A start seen during the DONE
// cycle is accepted immediately (back-to-back); start while busy is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_div_unit_if.slave        bus,
  output logic [2:0]            state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] a_in_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Booth add is one bit wider than the operands so -2^31 * -2^31 cannot overflow acc.
  assign acc_ext  = {acc_q[WIDTH-1], acc_q};
  assign a_ext    = {a_q[WIDTH-1], a_q};
  assign a_in_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;

  always_comb begin
    booth_sum = acc_ext;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_ext + a_ext;
      2'b10:   booth_sum = acc_ext - a_ext;
      default: booth_sum = acc_ext;
    endcase
  end

  // The stored remainder is always below |b|, so the 33-bit shifted value stays under
  // 2*|b| and the sign of the 33-bit difference is a valid "fits" test.
  assign rem_shift = {rem_q, mq_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_mag};
  assign rem_ge    = ~rem_diff[WIDTH];

  assign quot_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mq_q : mq_q;
  assign rem_fix  = a_q[WIDTH-1] ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    qm1_d      = qm1_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    dz_pend_d  = dz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.start) begin
          op_d       = bus.op;
          a_d        = bus.a;
          b_d        = bus.b;
          div_zero_d = 1'b0;
          dz_pend_d  = 1'b0;
          cnt_d      = CW'(WIDTH - 1);
          busy_d     = 1'b1;
          acc_d      = '0;
          qm1_d      = 1'b0;
          rem_d      = '0;
          if (!bus.op) begin
            mq_d    = bus.b;
            state_d = S_MUL;
          end else if (bus.b == '0) begin
            // Skip the iterations; FIX flags the error and leaves HI/LO alone.
            dz_pend_d = 1'b1;
            state_d   = S_FIX;
          end else begin
            mq_d    = a_in_mag;
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        acc_d = booth_sum[WIDTH:1];
        mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end

      S_DIV: begin
        rem_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end

      S_FIX: begin
        if (dz_pend_q) begin
          div_zero_d = 1'b1;
        end else if (!op_q) begin
          hi_d = acc_q;
          lo_d = mq_q;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        dz_pend_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      qm1_q      <= 1'b0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      dz_pend_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      qm1_q      <= qm1_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      dz_pend_q  <= dz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed stimulus for mult_div_unit; a reference model built on
// 64-bit integer arithmetic fills an expected queue that a monitor drains on done.
module tb_mult_div_unit;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // scoreboard state: {div_zero, hi, lo}
  logic [2*W:0] exp_q[$];
  int unsigned  exp_lat_q[$];
  int unsigned  start_cyc_q[$];
  logic [W-1:0] m_hi, m_lo;
  logic [W-1:0] shown_hi, shown_lo;
  int           busy_run;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain signed 64-bit arithmetic
  task automatic model_push(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    longint sa, sb, p, q, r;
    logic   dz;
    int unsigned lat;
    sa  = longint'($signed(a_i));
    sb  = longint'($signed(b_i));
    dz  = 1'b0;
    lat = 33;
    if (!op_i) begin
      p    = sa * sb;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (b_i == '0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      m_hi = r[31:0];
      m_lo = q[31:0];
    end
    exp_q.push_back({dz, m_hi, m_lo});
    exp_lat_q.push_back(lat);
  endtask

  // driver tasks: called at a negedge while the unit is IDLE or DONE
  task automatic issue(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
    model_push(op_i, a_i, b_i);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    #1;
    start_cyc_q.push_back(cyc);
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    compared++;
    mismatched++;
    $display("FAIL done_timeout: got no done within 200 cycles expected done (t=%0t)", $time);
  endtask

  task automatic pulse_reset_midop(input int cycles_in);
    repeat (cycles_in) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_state_idle", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_lat_q.delete();
    start_cyc_q.delete();
    m_hi     = '0;
    m_lo     = '0;
    shown_hi = '0;
    shown_lo = '0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [2*W:0] e;
    int unsigned  lat, s;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (bus.busy) begin
        busy_run++;
        check("hi_stable_busy", 64'(bus.hi), 64'(shown_hi));
        check("lo_stable_busy", 64'(bus.lo), 64'(shown_lo));
        check("div_zero_clr_busy", 64'(bus.div_zero), 64'd0);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done expected none (t=%0t)", $time);
        end else begin
          e   = exp_q.pop_front();
          lat = exp_lat_q.pop_front();
          s   = start_cyc_q.pop_front();
          check("hi", 64'(bus.hi), 64'(e[2*W-1:W]));
          check("lo", 64'(bus.lo), 64'(e[W-1:0]));
          check("div_zero", 64'(bus.div_zero), 64'(e[2*W]));
          check("latency", 64'(cyc - s), 64'(lat));
          check("busy_cycles", 64'(busy_run), 64'(lat));
          check("busy_and_done", 64'(bus.busy), 64'd0);
          shown_hi = e[2*W-1:W];
          shown_lo = e[W-1:0];
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    logic         r_op;
    logic [W-1:0] r_a, r_b;
    m_hi      = '0;
    m_lo      = '0;
    shown_hi  = '0;
    shown_lo  = '0;
    busy_run  = 0;
    // reset held together with start: reset must win
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    repeat (3) @(negedge clk);
    check("init_busy", 64'(bus.busy), 64'd0);
    check("init_done", 64'(bus.done), 64'd0);
    check("init_div_zero", 64'(bus.div_zero), 64'd0);
    check("init_hi", 64'(bus.hi), 64'd0);
    check("init_lo", 64'(bus.lo), 64'd0);
    check("init_state", 64'(state_dbg), 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // directed: multiply, extremes, divide signs, zero divisor, overflow + back-to-back
    issue(1'b0, 32'd7, W'(-3));             wait_done(); @(negedge clk);
    issue(1'b0, 32'h80000000, 32'h80000000); wait_done(); @(negedge clk);
    issue(1'b1, W'(-7), 32'd2);             wait_done(); @(negedge clk);
    issue(1'b1, 32'd7, W'(-2));             wait_done(); @(negedge clk);
    issue(1'b1, 32'h451, 32'h20);           wait_done(); @(negedge clk);
    issue(1'b1, 32'd5, 32'd0);              wait_done(); @(negedge clk);
    issue(1'b0, 32'd2, 32'd9);              wait_done(); @(negedge clk);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF); wait_done();
    issue(1'b0, W'(-5), 32'd6);             wait_done();
    issue(1'b1, 32'd9, 32'd0);              wait_done();
    issue(1'b1, 32'd100, 32'd7);

    // start pulsed mid-operation must be ignored
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // reset in the middle of a divide, then a fresh multiply
    issue(1'b1, 32'd1000, 32'd3);
    pulse_reset_midop(14);
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd4);              wait_done(); @(negedge clk);

    // randomised operations with random idle gaps (gap 0 = back-to-back)
    for (int n = 0; n < 40; n++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = '0;
        1:       r_b = 32'hFFFFFFFF;
        2:       r_b = W'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) r_a = W'($urandom_range(0, 50)) - 32'd25;
      issue(r_op, r_a, r_b);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
